// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Round sequencer for the AES-SMALL iterative datapath.
//
// A block starts with a start/in_ready handshake. The controller then runs
// one LOAD cycle (count=1: the state mux takes the input words and the key
// schedule loads the cipher key). It follows with NUM_ROUNDS round cycles
// (count=2..NUM_ROUNDS+1: the state mux takes the round feedback and the key
// schedule advances). It then holds the result in DONE until the
// out_valid/out_ready handshake completes.
//
// Optional feature macro: AES_ROUND_ABORT_EN
//   When defined, an extra 'abort' input returns the controller to IDLE from
//   LOAD, ROUND or DONE at the next edge. When it is undefined, every
//   accepted block runs to DONE.
//
// Ports:
//   clk         in   rising-edge system clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request one block (taken only while in_ready=1)
//   in_ready    out  idle, start will be accepted
//   count       out  round index / state mux select (0 idle, 1 load, 2.. rounds)
//   state_we    out  state register write enable
//   key_flag    out  load cipher key into key schedule
//   key_step    out  advance key schedule by one round key
//   last_round  out  final round (MixColumns bypassed)
//   out_valid   out  result in state register is valid
//   out_ready   in   downstream accepts the result
//   busy        out  controller not idle
//   abort       in   (AES_ROUND_ABORT_EN only) drop the in-flight block
//
// All outputs come straight from flops. Their next values are decoded from
// the next state, so no input reaches an output without a register between.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             in_ready,
   output logic [CNT_W-1:0] count,
   output logic             state_we,
   output logic             key_flag,
   output logic             key_step,
   output logic             last_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
`ifdef AES_ROUND_ABORT_EN
   ,
   input  logic             abort
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_ROUNDS + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             abort_s;

   logic in_ready_q,   in_ready_d;
   logic state_we_q,   state_we_d;
   logic key_flag_q,   key_flag_d;
   logic key_step_q,   key_step_d;
   logic last_round_q, last_round_d;
   logic out_valid_q,  out_valid_d;
   logic busy_q,       busy_d;

`ifdef AES_ROUND_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // Next state and round counter; abort outranks both round advance and out_ready.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               count_d = CNT_LOAD;
            end else begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end
         end
         ST_LOAD: begin
            if (abort_s) begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end else begin
               state_d = ST_ROUND;
               count_d = CNT_FIRST;
            end
         end
         ST_ROUND: begin
            if (abort_s) begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end else if (count_q == CNT_LAST) begin
               // Final round done: count freezes at NUM_ROUNDS+1, never wraps.
               state_d = ST_DONE;
               count_d = count_q;
            end else begin
               state_d = ST_ROUND;
               count_d = count_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            // start is deliberately ignored here, even alongside out_ready.
            if (abort_s || out_ready) begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end else begin
               state_d = ST_DONE;
               count_d = count_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
         end
      endcase
   end

   // Decode of the next state into next output values, so outputs are flops.
   always_comb begin
      in_ready_d   = 1'b0;
      state_we_d   = 1'b0;
      key_flag_d   = 1'b0;
      key_step_d   = 1'b0;
      last_round_d = 1'b0;
      out_valid_d  = 1'b0;
      busy_d       = 1'b1;
      case (state_d)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
         ST_LOAD: begin
            state_we_d = 1'b1;
            key_flag_d = 1'b1;
         end
         ST_ROUND: begin
            state_we_d   = 1'b1;
            key_step_d   = 1'b1;
            last_round_d = (count_d == CNT_LAST);
         end
         ST_DONE: begin
            out_valid_d = 1'b1;
         end
         default: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with asynchronous reset to idle values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= CNT_ZERO;
         in_ready_q   <= 1'b1;
         state_we_q   <= 1'b0;
         key_flag_q   <= 1'b0;
         key_step_q   <= 1'b0;
         last_round_q <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         state_we_q   <= state_we_d;
         key_flag_q   <= key_flag_d;
         key_step_q   <= key_step_d;
         last_round_q <= last_round_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign count      = count_q;
   assign state_we   = state_we_q;
   assign key_flag   = key_flag_q;
   assign key_step   = key_step_q;
   assign last_round = last_round_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Three controllers (NUM_ROUNDS = 10, 12, 14) share clock, reset and
// handshake stimulus. A timeline model tracks, per instance, how many edges
// have passed since its block was accepted. It derives every output from
// that elapsed time. A monitor compares all outputs with the model on every
// falling edge. Directed literal checks pin key points of the timeline.
// Output vector layout:
// {in_ready, count[3:0], state_we, key_flag, key_step, last_round, out_valid, busy}
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic out_ready;
    logic ab_s;
`ifdef AES_ROUND_ABORT_EN
    logic abort;
    assign ab_s = abort;
`else
    assign ab_s = 1'b0;
`endif

    always #5 clk = ~clk;

    logic       ir [3];
    logic [3:0] cnt [3];
    logic       sw [3];
    logic       kf [3];
    logic       ks [3];
    logic       lr [3];
    logic       ov [3];
    logic       bz [3];
    logic [10:0] dut_vec [3];

    for (genvar g = 0; g < 3; g++) begin : g_vec
        assign dut_vec[g] = {ir[g], cnt[g], sw[g], kf[g], ks[g], lr[g], ov[g], bz[g]};
    end

    aes_round_ctrl #(.NUM_ROUNDS(10), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(ir[0]), .count(cnt[0]),
        .state_we(sw[0]), .key_flag(kf[0]), .key_step(ks[0]), .last_round(lr[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0])
`ifdef AES_ROUND_ABORT_EN
        , .abort(abort)
`endif
    );
    aes_round_ctrl #(.NUM_ROUNDS(12), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(ir[1]), .count(cnt[1]),
        .state_we(sw[1]), .key_flag(kf[1]), .key_step(ks[1]), .last_round(lr[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1])
`ifdef AES_ROUND_ABORT_EN
        , .abort(abort)
`endif
    );
    aes_round_ctrl #(.NUM_ROUNDS(14), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(ir[2]), .count(cnt[2]),
        .state_we(sw[2]), .key_flag(kf[2]), .key_step(ks[2]), .last_round(lr[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2])
`ifdef AES_ROUND_ABORT_EN
        , .abort(abort)
`endif
    );

    // ---------------- timeline model ----------------
    bit active [3];
    int elapsed [3];

    function automatic int nr(input int i);
        return 10 + 2 * i;
    endfunction

    // Track blocks: accepted when idle, one edge per step, done after NR+1 steps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                active[i]  <= 1'b0;
                elapsed[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!active[i]) begin
                    if (start) begin
                        active[i]  <= 1'b1;
                        elapsed[i] <= 1;
                    end
                end else if (ab_s) begin
                    active[i] <= 1'b0;
                end else if (elapsed[i] >= nr(i) + 2) begin
                    if (out_ready) active[i] <= 1'b0;
                end else begin
                    elapsed[i] <= elapsed[i] + 1;
                end
            end
        end
    end

    function automatic logic [10:0] exp_vec(input int i);
        int e;
        int n;
        e = elapsed[i];
        n = nr(i);
        if (!active[i])   return {1'b1, 4'd0, 6'b000000};
        if (e == 1)       return {1'b0, 4'd1, 6'b110001};
        if (e <= n + 1)   return {1'b0, 4'(e), 1'b1, 1'b0, 1'b1, (e == n + 1), 1'b0, 1'b1};
        return {1'b0, 4'(n + 1), 6'b000011};
    endfunction

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((active[0] || active[1] || active[2]) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", k < 100, 1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int first_k;
        int second_k;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
`ifdef AES_ROUND_ABORT_EN
        abort = 1'b0;
`endif
        fork
            begin
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 3; i++) begin
                        n_cmp++;
                        if (dut_vec[i] !== exp_vec(i)) begin
                            n_bad++;
                            $display("FAIL cycle_check inst%0d at %0t: got %b, expected %b",
                                     i, $time, dut_vec[i], exp_vec(i));
                        end
                    end
                end
            end
            begin
                // Reset state
                repeat (3) @(negedge clk);
                chk("rst_vec0", int'(dut_vec[0]), int'(11'b1_0000_000000));
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_in_ready", int'(ir[0]), 1);
                chk("post_rst_count", int'(cnt[0]), 0);

                // Nominal run with out_ready high
                out_ready = 1'b1;
                start = 1'b1;
                for (int k = 1; k <= 17; k++) begin
                    @(negedge clk);
                    start = 1'b0;
                    if (k == 1)  begin chk("nom_k1_count", int'(cnt[0]), 1);  chk("nom_k1_keyflag", int'(kf[0]), 1); chk("nom_k1_keystep", int'(ks[0]), 0); end
                    if (k == 2)  begin chk("nom_k2_count", int'(cnt[0]), 2);  chk("nom_k2_keyflag", int'(kf[0]), 0); end
                    if (k == 10) begin chk("nom_k10_last", int'(lr[0]), 0); end
                    if (k == 11) begin chk("nom_k11_count", int'(cnt[0]), 11); chk("nom_k11_last", int'(lr[0]), 1); chk("nom_k11_ov", int'(ov[0]), 0); end
                    if (k == 12) begin chk("nom_k12_ov", int'(ov[0]), 1); chk("nom_k12_we", int'(sw[0]), 0); chk("nom_k12_count", int'(cnt[0]), 11); end
                    if (k == 13) begin chk("nom_k13_in_ready", int'(ir[0]), 1); chk("nom_k13_ov", int'(ov[0]), 0); chk("nom_k13_count", int'(cnt[0]), 0); end
                    if (k == 14) begin chk("nr12_k14_ov", int'(ov[1]), 1); chk("nr12_k14_count", int'(cnt[1]), 13); end
                    if (k == 15) begin chk("nr14_k15_count", int'(cnt[2]), 15); chk("nr14_k15_last", int'(lr[2]), 1); end
                    if (k == 16) begin chk("nr14_k16_ov", int'(ov[2]), 1); chk("nr14_k16_count", int'(cnt[2]), 15); end
                end
                wait_idle();

                // Backpressure: hold out_ready low for 20 cycles after out_valid
                out_ready = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (11) @(negedge clk);
                repeat (20) @(negedge clk);
                chk("bp_ov", int'(ov[0]), 1);
                chk("bp_we", int'(sw[0]), 0);
                chk("bp_count", int'(cnt[0]), 11);
                chk("bp_nr14_count", int'(cnt[2]), 15);
                out_ready = 1'b1;
                @(negedge clk);
                chk("bp_release_in_ready", int'(ir[0]), 1);
                chk("bp_release_ov", int'(ov[0]), 0);
                wait_idle();

                // Start while busy (count=4) and in DONE together with out_ready
                out_ready = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                chk("busy_k4_count", int'(cnt[0]), 4);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_k5_count", int'(cnt[0]), 5);
                repeat (7) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                chk("busy_done_ov", int'(ov[0]), 1);
                out_ready = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_done_no_load", int'(cnt[0]), 0);
                chk("busy_done_in_ready", int'(ir[0]), 1);
                wait_idle();

                // Back-to-back: start held high, spacing between LOAD cycles
                out_ready = 1'b1;
                start = 1'b1;
                first_k = -1;
                second_k = -1;
                for (int k = 1; k <= 40; k++) begin
                    @(negedge clk);
                    if (cnt[0] == 4'd1) begin
                        if (first_k < 0) first_k = k;
                        else if (second_k < 0) second_k = k;
                    end
                end
                start = 1'b0;
                chk("b2b_spacing", second_k - first_k, 13);
                wait_idle();

                // Reset in the middle of a block (count=5)
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (4) @(negedge clk);
                chk("mid_rst_pre_count", int'(cnt[0]), 5);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                for (int i = 0; i < 3; i++)
                    chk("mid_rst_async_vec", int'(dut_vec[i]), int'(11'b1_0000_000000));
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("mid_rst_after_in_ready", int'(ir[0]), 1);
                chk("mid_rst_after_count", int'(cnt[0]), 0);
                repeat (15) @(negedge clk);
                chk("mid_rst_no_ov", int'(ov[0]), 0);

`ifdef AES_ROUND_ABORT_EN
                // Abort at count=6, then a full clean block
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (5) @(negedge clk);
                chk("abort_pre_count", int'(cnt[0]), 6);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_count", int'(cnt[0]), 0);
                chk("abort_in_ready", int'(ir[0]), 1);
                chk("abort_ov", int'(ov[0]), 0);
                repeat (15) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (11) @(negedge clk);
                chk("abort_rerun_ov", int'(ov[0]), 1);
                wait_idle();
`endif
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
